// File: rtl/trace_pkg.sv
// Shared encodings for the trace capture block: FSM states and trigger modes.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam logic [1:0] TRIG_IMM    = 2'd0;
  localparam logic [1:0] TRIG_STATE  = 2'd1;
  localparam logic [1:0] TRIG_CH0    = 2'd2;
  localparam logic [1:0] TRIG_MANUAL = 2'd3;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 137
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: store the entry on the edge it is presented.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read port: registered output, cleared by reset so Rd_Data starts at zero.
  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Triggerable circular trace buffer with pre/post-trigger windows and
// oldest-first request/acknowledge readout.
module cpu_trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PRE_TRIG = 4,
  parameter int unsigned STATE_W  = 9
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic [CHANNELS*WIDTH-1:0]           Sample_In,
  input  logic [STATE_W-1:0]                  State_In,
  input  logic                                Sample_En,
  input  logic                                Arm,
  input  logic [1:0]                          Trig_Mode,
  input  logic [STATE_W-1:0]                  Trig_State,
  input  logic [WIDTH-1:0]                    Trig_Value,
  input  logic                                Force_Trig,
  input  logic                                Rd_Req,
  output logic                                Rd_Ack,
  output logic [CHANNELS*WIDTH+STATE_W-1:0]   Rd_Data,
  output logic                                Rd_Last,
  output logic                                Armed,
  output logic                                Triggered,
  output logic                                Done,
  output logic [$clog2(DEPTH):0]              Count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = CHANNELS*WIDTH + STATE_W;

  localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);
  localparam logic [CW-1:0] PRE_N   = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_N  = CW'(DEPTH - PRE_TRIG);
  localparam logic [CW-1:0] ONE_N   = CW'(1);

  trace_state_e  state_q, state_d;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fill;
  logic [CW-1:0] pre_q;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] rd_idx;
  logic          force_pend;

  logic          sample_we;
  logic          hit_match;
  logic          trig_hit;
  logic          post_done;
  logic          rd_issue;
  logic          rd_end;
  logic [CW-1:0] pre_now;
  logic [CW-1:0] post_next;

  // Trigger qualification and handshake decode for the current cycle.
  always_comb begin
    hit_match = 1'b0;
    case (Trig_Mode)
      TRIG_IMM:    hit_match = 1'b1;
      TRIG_STATE:  hit_match = (State_In == Trig_State);
      TRIG_CH0:    hit_match = (Sample_In[WIDTH-1:0] == Trig_Value);
      TRIG_MANUAL: hit_match = 1'b0;
      default:     hit_match = 1'b0;
    endcase
    sample_we = Sample_En && ((state_q == ST_ARMED) || (state_q == ST_POST));
    // A same-cycle Force_Trig and match collapse into one trigger event.
    trig_hit  = (state_q == ST_ARMED) && Sample_En &&
                (hit_match || force_pend || Force_Trig);
    pre_now   = (fill < PRE_N) ? fill : PRE_N;
    post_next = post_cnt + ONE_N;
    post_done = (state_q == ST_POST) && Sample_En && (post_next == POST_N);
    rd_end    = (state_q == ST_DONE) && Rd_Ack && Rd_Last;
    rd_issue  = (state_q == ST_DONE) && Rd_Req && !rd_end;
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: trigger is resolved before the completion check, so a
  // one-entry post window goes straight from ARMED to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Arm) state_d = ST_ARMED;
      ST_ARMED: if (trig_hit) state_d = (POST_N == ONE_N) ? ST_DONE : ST_POST;
      ST_POST:  if (post_done) state_d = ST_DONE;
      ST_DONE:  if (rd_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture pointers, trigger bookkeeping and readout sequencing.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      pre_q      <= '0;
      post_cnt   <= '0;
      rd_idx     <= '0;
      force_pend <= 1'b0;
      Count      <= '0;
      Rd_Ack     <= 1'b0;
      Rd_Last    <= 1'b0;
    end else begin
      Rd_Ack  <= 1'b0;
      Rd_Last <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Arm) begin
            wr_ptr     <= '0;
            fill       <= '0;
            force_pend <= 1'b0;
            Count      <= '0;
          end
        end
        ST_ARMED: begin
          if (Sample_En) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != DEPTH_N) fill <= fill + ONE_N;
          end
          if (trig_hit) begin
            // Readout starts at the oldest retained pre-trigger entry.
            pre_q      <= pre_now;
            rd_ptr     <= wr_ptr - pre_now[AW-1:0];
            rd_idx     <= '0;
            post_cnt   <= ONE_N;
            force_pend <= 1'b0;
            if (POST_N == ONE_N) Count <= pre_now + POST_N;
          end else if (Force_Trig) begin
            force_pend <= 1'b1;
          end
        end
        ST_POST: begin
          if (Sample_En) begin
            wr_ptr   <= wr_ptr + 1'b1;
            post_cnt <= post_next;
            if (fill != DEPTH_N) fill <= fill + ONE_N;
          end
          if (post_done) Count <= pre_q + POST_N;
        end
        ST_DONE: begin
          if (rd_issue) begin
            Rd_Ack  <= 1'b1;
            Rd_Last <= (rd_idx == Count - ONE_N);
            rd_ptr  <= rd_ptr + 1'b1;
            rd_idx  <= rd_idx + ONE_N;
          end
        end
        default: ;
      endcase
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .clk     (Clock),
    .rst     (Reset),
    .we      (sample_we),
    .wr_addr (wr_ptr),
    .wr_data ({State_In, Sample_In}),
    .re      (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (Rd_Data)
  );

  assign Armed     = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign Triggered = (state_q == ST_POST)  || (state_q == ST_DONE);
  assign Done      = (state_q == ST_DONE);

endmodule
